// File: rtl/branch_pkg.sv
// Shared encodings and constants for the branch predict unit.
package branch_pkg;

    localparam int unsigned CTR_W = 2;

    // EX-stage condition codes
    typedef enum logic [2:0] {
        COND_NONE = 3'b000,
        COND_EQ   = 3'b001,
        COND_NE   = 3'b010,
        COND_LT   = 3'b011,
        COND_GE   = 3'b100,
        COND_LE   = 3'b101,
        COND_JAL  = 3'b110,
        COND_RSVD = 3'b111
    } cond_e;

    // 2-bit saturating counter states
    localparam logic [CTR_W-1:0] CTR_STRONG_NT = 2'b00;
    localparam logic [CTR_W-1:0] CTR_WEAK_NT   = 2'b01;
    localparam logic [CTR_W-1:0] CTR_WEAK_T    = 2'b10;
    localparam logic [CTR_W-1:0] CTR_STRONG_T  = 2'b11;

    // True for the conditional branch codes that train the BHT (eq..le)
    function automatic logic is_cond_branch(input logic [2:0] cond);
        return (cond >= 3'(COND_EQ)) && (cond <= 3'(COND_LE));
    endfunction

endpackage

// File: rtl/sat_counter2.sv
// Next-state function of a 2-bit saturating taken/not-taken counter.
module sat_counter2
    import branch_pkg::*;
(
    input  logic [CTR_W-1:0] cur_i,
    input  logic             taken_i,
    output logic [CTR_W-1:0] ctr_next_c
);

    // Step toward the resolved direction, holding at either end
    always_comb begin
        ctr_next_c = cur_i;
        if (taken_i) begin
            if (cur_i != CTR_STRONG_T) ctr_next_c = cur_i + CTR_W'(1);
        end else begin
            if (cur_i != CTR_STRONG_NT) ctr_next_c = cur_i - CTR_W'(1);
        end
    end

endmodule

// File: rtl/branch_predict_unit.sv
// Branch resolution unit with a 2-bit saturating BHT and registered
// flush/redirect. Optional statistics counters: define BRANCH_STATS_EN.
module branch_predict_unit
    import branch_pkg::*;
#(
    parameter int unsigned      XLEN      = 32,
    parameter int unsigned      BHT_DEPTH = 64,
    parameter logic [CTR_W-1:0] CTR_INIT  = CTR_WEAK_NT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] if_pc,
    output logic            if_pred_taken,
    input  logic            ex_valid,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [2:0]      ex_cond,
    input  logic            ex_zero,
    input  logic            ex_less,
    input  logic            ex_pred_taken,
    input  logic [XLEN-1:0] ex_target,
    output logic            ex_taken,
    output logic            flush,
    output logic [XLEN-1:0] redirect_pc
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0]     stat_branches,
    output logic [31:0]     stat_mispredicts
`endif
);

    localparam int unsigned IDX = $clog2(BHT_DEPTH);

    logic [CTR_W-1:0] bht_q [BHT_DEPTH];
    logic [IDX-1:0]   if_idx;
    logic [IDX-1:0]   ex_idx;
    logic [CTR_W-1:0] ctr_upd;
    logic             active;
    logic             bht_we;
    logic             mispredict;
    logic             flush_q;
    logic             flush_d;
    logic [XLEN-1:0]  redirect_q;
    logic [XLEN-1:0]  redirect_d;
    logic             unused_pc_bits;

    assign if_idx = if_pc[IDX+1:2];
    assign ex_idx = ex_pc[IDX+1:2];
    assign unused_pc_bits = ^{if_pc[XLEN-1:IDX+2], if_pc[1:0], ex_pc[1:0]};

    // Fetch prediction reads the pre-update counter
    assign if_pred_taken = bht_q[if_idx][CTR_W-1];

    // Resolve branch outcome from ALU flags
    always_comb begin
        ex_taken = 1'b0;
        case (ex_cond)
            COND_EQ:  ex_taken = ex_zero;
            COND_NE:  ex_taken = ~ex_zero;
            COND_LT:  ex_taken = ex_less;
            COND_GE:  ex_taken = ex_zero | ~ex_less;
            COND_LE:  ex_taken = ex_zero | ex_less;
            COND_JAL: ex_taken = 1'b1;
            default:  ex_taken = 1'b0;
        endcase
    end

    // The slot right after a flush is wrong-path and must be ignored
    assign active     = ex_valid & ~flush_q & (ex_cond != COND_NONE) & (ex_cond != COND_RSVD);
    assign bht_we     = active & is_cond_branch(ex_cond);
    assign mispredict = active & (ex_taken != ex_pred_taken);

    sat_counter2 u_ctr (
        .cur_i      (bht_q[ex_idx]),
        .taken_i    (ex_taken),
        .ctr_next_c (ctr_upd)
    );

    // Next flush/redirect; redirect holds when there is no mispredict
    always_comb begin
        flush_d    = mispredict;
        redirect_d = redirect_q;
        if (mispredict) redirect_d = ex_taken ? ex_target : ex_pc + XLEN'(4);
    end

    // BHT and flush/redirect state
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < BHT_DEPTH; i++) bht_q[i] <= CTR_INIT;
            flush_q    <= 1'b0;
            redirect_q <= '0;
        end else begin
            if (bht_we) bht_q[ex_idx] <= ctr_upd;
            flush_q    <= flush_d;
            redirect_q <= redirect_d;
        end
    end

    assign flush       = flush_q;
    assign redirect_pc = redirect_q;

`ifdef BRANCH_STATS_EN
    logic [31:0] stat_br_q;
    logic [31:0] stat_mis_q;

    // Free-running wrap-around event counters
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_br_q  <= '0;
            stat_mis_q <= '0;
        end else begin
            if (bht_we)     stat_br_q  <= stat_br_q + 32'(1);
            if (mispredict) stat_mis_q <= stat_mis_q + 32'(1);
        end
    end

    assign stat_branches    = stat_br_q;
    assign stat_mispredicts = stat_mis_q;
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// Self-checking bench for branch_predict_unit: directed table plus random
// stimulus against a behavioural model.
module tb_branch_predict_unit;

    typedef struct {
        logic        rst;
        logic [31:0] if_pc;
        logic        valid;
        logic [31:0] pc;
        logic [2:0]  cond;
        logic        z;
        logic        l;
        logic        pred;
        logic [31:0] tgt;
        logic        e_pred;
        logic        e_taken;
        logic        e_flush;
        logic [31:0] e_redir;
    } vec_t;

    logic        clk;
    logic        rst;
    logic [31:0] if_pc;
    logic        if_pred_taken;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [2:0]  ex_cond;
    logic        ex_zero;
    logic        ex_less;
    logic        ex_pred_taken;
    logic [31:0] ex_target;
    logic        ex_taken;
    logic        flush;
    logic [31:0] redirect_pc;
`ifdef BRANCH_STATS_EN
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;
`endif

    int total = 0;
    int bad   = 0;

    // Behavioural model state
    int          m_ctr [64];
    bit          m_flush;
    logic [31:0] m_redir;
    logic [31:0] m_br;
    logic [31:0] m_mis;

    vec_t tbl[$];

    branch_predict_unit dut (
        .clk           (clk),
        .rst           (rst),
        .if_pc         (if_pc),
        .if_pred_taken (if_pred_taken),
        .ex_valid      (ex_valid),
        .ex_pc         (ex_pc),
        .ex_cond       (ex_cond),
        .ex_zero       (ex_zero),
        .ex_less       (ex_less),
        .ex_pred_taken (ex_pred_taken),
        .ex_target     (ex_target),
        .ex_taken      (ex_taken),
        .flush         (flush),
        .redirect_pc   (redirect_pc)
`ifdef BRANCH_STATS_EN
        ,
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
`endif
    );

    always #5 clk = ~clk;

    function automatic int idx(input logic [31:0] pc);
        return int'((pc >> 2) % 64);
    endfunction

    function automatic bit model_taken(input logic [2:0] c, input logic z, input logic l);
        case (c)
            3'd1:    return z;
            3'd2:    return !z;
            3'd3:    return l;
            3'd4:    return z || !l;
            3'd5:    return z || l;
            3'd6:    return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic vec_t mk(input logic r, input logic [31:0] ipc, input logic v,
                                input logic [31:0] pc, input logic [2:0] c, input logic z,
                                input logic l, input logic p, input logic [31:0] t,
                                input logic ep, input logic et, input logic ef,
                                input logic [31:0] er);
        vec_t x;
        x.rst = r; x.if_pc = ipc; x.valid = v; x.pc = pc; x.cond = c;
        x.z = z; x.l = l; x.pred = p; x.tgt = t;
        x.e_pred = ep; x.e_taken = et; x.e_flush = ef; x.e_redir = er;
        return x;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 64; i++) m_ctr[i] = 1;
        m_flush = 0;
        m_redir = '0;
        m_br    = '0;
        m_mis   = '0;
    endtask

    task automatic model_step(input vec_t v);
        bit tk;
        bit act;
        int k;
        if (v.rst) begin
            model_reset();
        end else begin
            tk  = model_taken(v.cond, v.z, v.l);
            act = v.valid && !m_flush && v.cond >= 3'd1 && v.cond <= 3'd6;
            k   = idx(v.pc);
            if (act && v.cond <= 3'd5) begin
                if (tk) m_ctr[k] = (m_ctr[k] >= 3) ? 3 : m_ctr[k] + 1;
                else    m_ctr[k] = (m_ctr[k] <= 0) ? 0 : m_ctr[k] - 1;
                m_br = m_br + 32'd1;
            end
            m_flush = act && (tk != v.pred);
            if (m_flush) begin
                m_redir = tk ? v.tgt : v.pc + 32'd4;
                m_mis   = m_mis + 32'd1;
            end
        end
    endtask

    // One clock of stimulus: check combinational outputs, step model, check registers
    task automatic apply(input vec_t v, input bit from_model);
        rst = v.rst; if_pc = v.if_pc; ex_valid = v.valid; ex_pc = v.pc;
        ex_cond = v.cond; ex_zero = v.z; ex_less = v.l;
        ex_pred_taken = v.pred; ex_target = v.tgt;
        #1;
        if (from_model) begin
            v.e_pred  = (m_ctr[idx(v.if_pc)] >= 2);
            v.e_taken = model_taken(v.cond, v.z, v.l);
        end
        check("if_pred_taken", 32'(if_pred_taken), 32'(v.e_pred));
        check("ex_taken", 32'(ex_taken), 32'(v.e_taken));
        model_step(v);
        if (from_model) begin
            v.e_flush = m_flush;
            v.e_redir = m_redir;
        end
        @(posedge clk);
        #1;
        check("flush", 32'(flush), 32'(v.e_flush));
        check("redirect_pc", redirect_pc, v.e_redir);
`ifdef BRANCH_STATS_EN
        check("stat_branches", stat_branches, m_br);
        check("stat_mispredicts", stat_mispredicts, m_mis);
`endif
    endtask

    initial begin
        vec_t v;
        clk = 0;
        rst = 1; if_pc = '0; ex_valid = 0; ex_pc = '0; ex_cond = '0;
        ex_zero = 0; ex_less = 0; ex_pred_taken = 0; ex_target = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_flush", 32'(flush), 32'd0);
        check("reset_redirect", redirect_pc, 32'd0);

        // rst, if_pc, valid, pc, cond, z, l, pred, tgt | pred, taken, flush, redirect
        tbl.push_back(mk(0, 'h100, 0, 'h0,   3'd0, 0, 0, 0, 'h0,   0, 0, 0, 'h0));
        tbl.push_back(mk(0, 'h100, 1, 'h100, 3'd1, 1, 0, 0, 'h200, 0, 1, 1, 'h200));
        tbl.push_back(mk(0, 'h100, 0, 'h0,   3'd0, 0, 0, 0, 'h0,   1, 0, 0, 'h200));
        tbl.push_back(mk(0, 'h100, 1, 'h100, 3'd1, 1, 0, 1, 'h200, 1, 1, 0, 'h200));
        tbl.push_back(mk(0, 'h100, 1, 'h100, 3'd1, 0, 0, 1, 'h200, 1, 0, 1, 'h104));
        tbl.push_back(mk(0, 'h100, 1, 'h100, 3'd1, 0, 0, 1, 'h200, 1, 0, 0, 'h104));
        tbl.push_back(mk(0, 'h100, 1, 'h100, 3'd1, 0, 0, 0, 'h200, 1, 0, 0, 'h104));
        tbl.push_back(mk(0, 'h100, 1, 'h100, 3'd1, 0, 0, 0, 'h200, 0, 0, 0, 'h104));
        tbl.push_back(mk(0, 'h100, 1, 'h100, 3'd1, 0, 0, 0, 'h200, 0, 0, 0, 'h104));
        tbl.push_back(mk(0, 'h100, 0, 'h0,   3'd0, 0, 0, 0, 'h0,   0, 0, 0, 'h104));
        tbl.push_back(mk(0, 'h100, 1, 'h100, 3'd1, 1, 0, 0, 'h200, 0, 1, 1, 'h200));
        tbl.push_back(mk(0, 'h40,  0, 'h0,   3'd0, 0, 0, 0, 'h0,   0, 0, 0, 'h200));
        tbl.push_back(mk(0, 'h40,  1, 'h40,  3'd4, 0, 1, 1, 'h300, 0, 0, 1, 'h44));
        tbl.push_back(mk(0, 'h80,  1, 'h80,  3'd1, 1, 0, 0, 'h500, 0, 1, 0, 'h44));
        tbl.push_back(mk(0, 'h80,  1, 'h80,  3'd1, 1, 0, 1, 'h500, 0, 1, 0, 'h44));
        tbl.push_back(mk(0, 'h80,  0, 'h0,   3'd0, 0, 0, 0, 'h0,   1, 0, 0, 'h44));
        tbl.push_back(mk(0, 'hC0,  1, 'hC0,  3'd6, 0, 0, 0, 'h600, 0, 1, 1, 'h600));
        tbl.push_back(mk(0, 'hC0,  0, 'h0,   3'd0, 0, 0, 0, 'h0,   0, 0, 0, 'h600));
        tbl.push_back(mk(0, 'hC0,  1, 'hC0,  3'd6, 0, 0, 1, 'h600, 0, 1, 0, 'h600));
        tbl.push_back(mk(0, 'h10,  1, 'h10,  3'd2, 0, 0, 0, 'h700, 0, 1, 1, 'h700));
        tbl.push_back(mk(1, 'h10,  0, 'h0,   3'd0, 0, 0, 0, 'h0,   1, 0, 0, 'h0));
        tbl.push_back(mk(0, 'h10,  0, 'h0,   3'd0, 0, 0, 0, 'h0,   0, 0, 0, 'h0));
        tbl.push_back(mk(0, 'h20,  1, 'h20,  3'd3, 0, 1, 0, 'h900, 0, 1, 1, 'h900));
        tbl.push_back(mk(0, 'h20,  0, 'h0,   3'd0, 0, 0, 0, 'h0,   1, 0, 0, 'h900));
        tbl.push_back(mk(0, 'h0,   1, 'hFFFFFFFC, 3'd5, 0, 0, 1, 'h10, 0, 0, 1, 'h0));
        tbl.push_back(mk(0, 'h0,   1, 'h30,  3'd7, 1, 1, 1, 'h10,  0, 0, 0, 'h0));

        foreach (tbl[i]) apply(tbl[i], 1'b0);

        // Random stimulus checked against the model
        for (int n = 0; n < 3000; n++) begin
            v.rst   = ($urandom_range(0, 149) == 0);
            v.pc    = {($urandom_range(0, 3) == 0) ? 24'($urandom) : 24'd0,
                       6'($urandom_range(0, 31)), 2'b00};
            v.if_pc = ($urandom_range(0, 1) == 0) ? v.pc
                                                  : {24'd0, 6'($urandom_range(0, 31)), 2'b00};
            v.valid = ($urandom_range(0, 9) != 0);
            v.cond  = 3'($urandom_range(0, 7));
            v.z     = 1'($urandom);
            v.l     = 1'($urandom);
            v.pred  = 1'($urandom);
            v.tgt   = $urandom;
            v.e_pred = 0; v.e_taken = 0; v.e_flush = 0; v.e_redir = '0;
            apply(v, 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/branch_predict_unit.md
# branch_predict_unit

Parametrised branch resolution unit with a 2-bit saturating branch history table (BHT). It replaces flat combinational branch decision logic. It predicts taken/not-taken at fetch and resolves branch conditions in execute. On a wrong prediction it issues a registered flush/redirect to the fetch stage. It sits between the ALU flags (`zero`, `less`) and the PC-select logic of the CPU pipeline.

## Interface
Parameters:
- `XLEN`, 32: PC and target width.
- `BHT_DEPTH`, 64: number of BHT entries; power of two, at least 2.
- `CTR_INIT`, 2'b01: reset value of every counter (weakly not-taken).

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst`, in, 1: reset, synchronous and active-high.
- `if_pc`, in, XLEN: fetch-stage PC used for lookup.
- `if_pred_taken`, out, 1: prediction for `if_pc`; combinational read of the BHT.
- `ex_valid`, in, 1: instruction in EX is valid.
- `ex_pc`, in, XLEN: PC of the EX instruction.
- `ex_cond`, in, 3: condition code. 000 none, 001 eq, 010 ne, 011 lt, 100 ge, 101 le, 110 jal, 111 reserved (treated as none).
- `ex_zero`, in, 1: ALU zero flag.
- `ex_less`, in, 1: ALU less-than flag.
- `ex_pred_taken`, in, 1: prediction carried down the pipe for this instruction.
- `ex_target`, in, XLEN: computed branch/jump target.
- `ex_taken`, out, 1: resolved outcome; combinational.
- `flush`, out, 1: registered mispredict pulse.
- `redirect_pc`, out, XLEN: registered correct next PC; valid while `flush` is high.

## Operation
- Index = `pc[IDX+1:2]`, where IDX = log2(BHT_DEPTH).
- Prediction: `if_pred_taken` = counter[index(if_pc)][1].
- Resolution of `ex_taken`:
  - eq: `zero`
  - ne: `~zero`
  - lt: `less`
  - ge: `zero | ~less`
  - le: `zero | less`
  - jal: 1
  - none/reserved: 0
- "Active" means `ex_valid` & ~`flush` & cond ≠ none/reserved. While `flush` is high, the EX instruction is wrong-path and is ignored entirely: no BHT update, no new flush.
- BHT update applies when active and cond is a conditional branch (001–101).
  - Taken: counter += 1, saturating at 11.
  - Not taken: counter -= 1, saturating at 00.
- jal never updates the BHT.
- Mispredict = active & (`ex_taken` ≠ `ex_pred_taken`).
- On the next edge after a mispredict:
  - `flush` ← 1.
  - `redirect_pc` ← `ex_taken` ? `ex_target` : `ex_pc` + 4. The +4 addition is modulo 2^XLEN; wrap-around is allowed.
- On the next edge with no mispredict: `flush` ← 0 and `redirect_pc` holds its value.
- A correct prediction produces no flush.

## Timing
- Reset (`rst` high at an edge): all counters ← CTR_INIT, `flush` ← 0, `redirect_pc` ← 0. Reset overrides any update in the same cycle. Reset mid-flush clears `flush` on that edge.
- Prediction latency is 0 cycles (combinational). Flush latency is 1 cycle after the EX cycle, and `flush` is high for exactly 1 cycle per mispredict.
- Back-to-back mispredicts cannot flush consecutively, because the cycle after a flush is masked.
- Same-cycle read and write of one entry (`if_pc` and `ex_pc` alias): `if_pred_taken` returns the pre-update value.
- Different PCs with the same index share a counter (aliasing is accepted).

## Configuration
- Macro `BRANCH_STATS_EN`.
- When defined, two extra output ports are added:
  - `stat_branches` [31:0]: counts active conditional branches.
  - `stat_mispredicts` [31:0]: counts active mispredicts, including jal.
  - Both counters reset to 0 on `rst` and wrap modulo 2^32.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

## Structure
- Package `branch_pkg`:
  - `ex_cond` encodings (COND_NONE, COND_EQ, COND_NE, COND_LT, COND_GE, COND_LE, COND_JAL).
  - Counter width constant (2).
  - Weak/strong counter state constants.
- Sub-module `sat_counter2`: pure function next = f(cur, taken), instantiated as the update path for the indexed entry.

## Test plan
- Reset, then `if_pc`=0x100 → `if_pred_taken`=0. Apply cond=eq, zero=1, pred=0, target=0x200 at pc 0x100 → `ex_taken`=1; next cycle `flush`=1 and `redirect_pc`=0x200; the cycle after, `flush`=0.
- Two taken beq at 0x100 → counter 01→10→11 and `if_pred_taken`=1. Then four not-taken → counter saturates at 00 with no underflow.
- cond=ge with less=1, zero=0, pred=1 at pc 0x40 → `ex_taken`=0, `flush`=1, `redirect_pc`=0x44.
- Mispredict at cycle N, then a valid mispredicting branch at N+1 → ignored: `flush` low at N+2 and that entry is unchanged.
- `if_pc`=`ex_pc`=0x80, counter 01, taken update → `if_pred_taken`=0 in that cycle and 1 in the next.
- jal with pred=0 → flush, redirect=target, BHT unchanged. With `BRANCH_STATS_EN`: `stat_mispredicts` increments and `stat_branches` does not. Assert `rst` mid-flush → `flush`=0 and both stats=0.
